// File: rtl/request_tracker.sv
`default_nettype none
// ============================================================================
// Module   : request_tracker
// Purpose  : Per-client pending-request counters feeding an arbiter, with
//            sticky overflow / illegal-grant flags and a registered grant echo.
// Revision : 1.0 - initial release
// ============================================================================
module request_tracker #(
    parameter int WID  = 16,
    parameter int CNTW = 3,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WID-1:0]  push,
    input  logic [WID-1:0]  grants,
    input  logic            clr,
    output logic [WID-1:0]  requests,
    output logic [WID-1:0]  overflow,
    output logic            grant_err,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic            busy
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [CNTW-1:0] cnt_q [WID];
    logic [CNTW-1:0] cnt_d [WID];
    logic [WID-1:0]  overflow_q, overflow_d;
    logic            grant_err_q, grant_err_d;
    logic            grant_valid_q, grant_valid_d;
    logic [IDXW-1:0] grant_idx_q, grant_idx_d;

    logic [WID-1:0]  w_dec;
    logic [WID-1:0]  w_ovf_set;
    logic [IDXW-1:0] w_low_idx;
    logic            w_grant_bad;

    always_comb begin
        for (int i = 0; i < WID; i++) begin
            w_dec[i]     = grants[i] && (cnt_q[i] != '0);
            cnt_d[i]     = cnt_q[i];
            w_ovf_set[i] = 1'b0;
            // Simultaneous push and grant cancel, so a full lane does not overflow.
            if (push[i] && !w_dec[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    w_ovf_set[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNTW'(1);
                end
            end else if (!push[i] && w_dec[i]) begin
                cnt_d[i] = cnt_q[i] - CNTW'(1);
            end
        end
    end

    always_comb begin
        w_low_idx = '0;
        for (int i = WID - 1; i >= 0; i--) begin
            if (w_dec[i]) begin
                w_low_idx = IDXW'(i);
            end
        end
    end

    // Illegal: grant to an empty lane, or more than one grant bit at once.
    assign w_grant_bad = ((grants & ~requests) != '0) ||
                         ((grants & (grants - WID'(1))) != '0);

    always_comb begin
        overflow_d    = (clr ? '0 : overflow_q) | w_ovf_set;
        grant_err_d   = (clr ? 1'b0 : grant_err_q) | w_grant_bad;
        grant_valid_d = |w_dec;
        grant_idx_d   = (|w_dec) ? w_low_idx : grant_idx_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WID; i++) begin
                cnt_q[i] <= '0;
            end
            overflow_q    <= '0;
            grant_err_q   <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
        end else begin
            for (int i = 0; i < WID; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            overflow_q    <= overflow_d;
            grant_err_q   <= grant_err_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
        end
    end

    for (genvar gi = 0; gi < WID; gi++) begin : g_req
        assign requests[gi] = (cnt_q[gi] != '0);
    end

    assign busy        = |requests;
    assign overflow    = overflow_q;
    assign grant_err   = grant_err_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_request_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_request_tracker
// Purpose  : Directed self-checking bench for request_tracker with a
//            count-based reference model and per-cycle output comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_request_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] push, grants;
    logic        clr;
    logic [15:0] requests, overflow;
    logic        grant_err, grant_valid, busy;
    logic [3:0]  grant_idx;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    // Reference model: plain integer pending counts per client.
    int          m_cnt [16];
    bit   [15:0] m_ovf;
    bit          m_err, m_gv;
    int          m_idx;

    int          t_nc, t_first;
    bit   [15:0] t_nov;
    bit          t_ne, t_d;

    request_tracker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .grants      (grants),
        .clr         (clr),
        .requests    (requests),
        .overflow    (overflow),
        .grant_err   (grant_err),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_cnt[i] <= 0;
            m_ovf <= '0;
            m_err <= 1'b0;
            m_gv  <= 1'b0;
            m_idx <= 0;
        end else begin
            t_nov   = '0;
            t_ne    = ($countones(grants) > 1);
            t_first = -1;
            for (int i = 0; i < 16; i++) begin
                if (grants[i] && m_cnt[i] == 0) t_ne = 1'b1;
                t_d = grants[i] && (m_cnt[i] > 0);
                if (t_d && t_first < 0) t_first = i;
                t_nc = m_cnt[i] + int'(push[i]) - int'(t_d);
                if (t_nc > 7) begin
                    t_nc     = 7;
                    t_nov[i] = 1'b1;
                end
                m_cnt[i] <= t_nc;
            end
            m_ovf <= (clr ? 16'h0 : m_ovf) | t_nov;
            m_err <= (clr ? 1'b0 : m_err) | t_ne;
            m_gv  <= (t_first >= 0);
            if (t_first >= 0) m_idx <= t_first;
        end
    end

    function automatic logic [15:0] model_req();
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = (m_cnt[i] != 0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("requests",    32'(requests),    32'(model_req()));
            chk("busy",        32'(busy),        32'(model_req() != 16'h0));
            chk("overflow",    32'(overflow),    32'(m_ovf));
            chk("grant_err",   32'(grant_err),   32'(m_err));
            chk("grant_valid", 32'(grant_valid), 32'(m_gv));
            chk("grant_idx",   32'(grant_idx),   32'(m_idx[3:0]));
        end
    end

    task automatic cycle(input logic [15:0] p, input logic [15:0] g, input logic c, input logic r);
        push   = p;
        grants = g;
        clr    = c;
        rst_n  = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    int          gcount [16];
    int          ptr;
    logic [15:0] g_rr;

    initial begin
        push = '0; grants = '0; clr = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        cycle(16'h0, 16'h0, 1'b0, 1'b0);
        started = 1'b1;
        chk("rst_requests",    32'(requests),    32'h0);
        chk("rst_overflow",    32'(overflow),    32'h0);
        chk("rst_grant_err",   32'(grant_err),   32'h0);
        chk("rst_grant_valid", 32'(grant_valid), 32'h0);
        chk("rst_busy",        32'(busy),        32'h0);

        // Single push / grant round trip on client 3.
        cycle(16'h0008, 16'h0, 1'b0, 1'b1);
        chk("push3_requests", 32'(requests), 32'h0008);
        cycle(16'h0, 16'h0008, 1'b0, 1'b1);
        chk("gnt3_requests", 32'(requests),    32'h0);
        chk("gnt3_valid",    32'(grant_valid), 32'h1);
        chk("gnt3_idx",      32'(grant_idx),   32'h3);
        cycle(16'h0, 16'h0, 1'b0, 1'b1);
        chk("idle_valid", 32'(grant_valid), 32'h0);

        // Saturation of client 0.
        for (int n = 1; n <= 9; n++) begin
            cycle(16'h0001, 16'h0, 1'b0, 1'b1);
            if (n == 7) chk("ovf0_before", 32'(overflow[0]), 32'h0);
            if (n == 8) chk("ovf0_at8",    32'(overflow[0]), 32'h1);
        end
        for (int n = 1; n <= 7; n++) begin
            cycle(16'h0, 16'h0001, 1'b0, 1'b1);
            if (n == 6) chk("req0_after6", 32'(requests[0]), 32'h1);
            if (n == 7) chk("req0_after7", 32'(requests[0]), 32'h0);
        end
        cycle(16'h0, 16'h0, 1'b1, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'h0);

        // Full lane with simultaneous push and grant.
        for (int n = 0; n < 7; n++) cycle(16'h0020, 16'h0, 1'b0, 1'b1);
        cycle(16'h0020, 16'h0020, 1'b0, 1'b1);
        chk("pg5_ovf", 32'(overflow[5]), 32'h0);
        chk("pg5_idx", 32'(grant_idx),   32'h5);
        for (int n = 0; n < 7; n++) cycle(16'h0, 16'h0020, 1'b0, 1'b1);
        chk("pg5_drained", 32'(requests), 32'h0);

        // Grant to an empty lane, clear, and clear racing a new error.
        cycle(16'h0, 16'h0100, 1'b0, 1'b1);
        chk("gerr_set",   32'(grant_err),   32'h1);
        chk("gerr_valid", 32'(grant_valid), 32'h0);
        cycle(16'h0, 16'h0, 1'b1, 1'b1);
        chk("gerr_clr", 32'(grant_err), 32'h0);
        cycle(16'h0, 16'h0200, 1'b1, 1'b1);
        chk("gerr_prio", 32'(grant_err), 32'h1);
        cycle(16'h0, 16'h0, 1'b1, 1'b1);

        // Multi-hot grant: error, but both lanes still decrement.
        cycle(16'h0006, 16'h0, 1'b0, 1'b1);
        cycle(16'h0, 16'h0006, 1'b0, 1'b1);
        chk("multi_err",  32'(grant_err),   32'h1);
        chk("multi_idx",  32'(grant_idx),   32'h1);
        chk("multi_req",  32'(requests),    32'h0);
        cycle(16'h0, 16'h0, 1'b1, 1'b1);

        // All clients twice, drained by a round-robin arbiter.
        cycle(16'hFFFF, 16'h0, 1'b0, 1'b1);
        cycle(16'hFFFF, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) gcount[i] = 0;
        ptr = 15;
        for (int n = 0; n < 32; n++) begin
            g_rr = '0;
            for (int k = 1; k <= 16; k++) begin
                if (g_rr == '0 && requests[(ptr + k) % 16]) begin
                    g_rr[(ptr + k) % 16] = 1'b1;
                    ptr = (ptr + k) % 16;
                end
            end
            if (g_rr != '0) gcount[ptr]++;
            cycle(16'h0, g_rr, 1'b0, 1'b1);
        end
        for (int i = 0; i < 16; i++) chk($sformatf("rr_count%0d", i), 32'(gcount[i]), 32'd2);
        chk("rr_busy", 32'(busy),      32'h0);
        chk("rr_err",  32'(grant_err), 32'h0);

        // Reset mid-operation dominates push/grant.
        for (int n = 0; n < 4; n++) cycle(16'h0004, 16'h0, 1'b0, 1'b1);
        chk("pre_rst_req", 32'(requests), 32'h0004);
        cycle(16'h0004, 16'h0004, 1'b0, 1'b0);
        chk("mrst_req",   32'(requests),    32'h0);
        chk("mrst_valid", 32'(grant_valid), 32'h0);
        chk("mrst_idx",   32'(grant_idx),   32'h0);
        chk("mrst_busy",  32'(busy),        32'h0);
        cycle(16'h0, 16'h0, 1'b0, 1'b1);
        chk("post_rst_valid", 32'(grant_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/request_tracker.md
REQUEST_TRACKER -- requirements
Module: request_tracker

Interface
REQ-001 Parameter WID, default 16, number of clients (request/grant lanes).
REQ-002 Parameter CNTW, default 3, width of each per-client pending counter (max pending = 2^CNTW-1 = 7).
REQ-003 Parameter IDXW, default 4, width of grant_idx; SHALL satisfy 2^IDXW >= WID.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-006 push  input  WID  per-client one-cycle request-enqueue pulses.
REQ-007 grants  input  WID  one-hot grant vector from downstream arbiter (round_robin).
REQ-008 clr  input  1  clears sticky error flags.
REQ-009 requests  output  WID  per-client pending indication, drives arbiter requests.
REQ-010 overflow  output  WID  sticky per-client overflow flag.
REQ-011 grant_err  output  1  sticky illegal-grant flag.
REQ-012 grant_valid  output  1  registered: a legal grant was consumed last cycle.
REQ-013 grant_idx  output  IDXW  registered index of the last consumed grant.
REQ-014 busy  output  1  OR of requests.

Function
REQ-015 Block SHALL hold one CNTW-bit counter cnt[i] per client.
REQ-016 requests[i] SHALL equal (cnt[i] != 0), decoded combinationally from registered state only; no combinational path from push or grants to requests.
REQ-017 inc[i] = push[i]; dec[i] = grants[i] AND cnt[i] != 0.
REQ-018 inc only, cnt[i] < max: cnt[i] increments by 1.
REQ-019 inc only, cnt[i] == max: cnt[i] holds at max, overflow[i] sets; push is dropped.
REQ-020 dec only: cnt[i] decrements by 1.
REQ-021 inc and dec same cycle: cnt[i] unchanged, no overflow even at max.
REQ-022 grants[i] with cnt[i] == 0: no counter change, grant_err sets.
REQ-023 More than one bit of grants set in a cycle: grant_err sets; each lane still decrements per REQ-017.
REQ-024 grant_valid SHALL be 1 in the cycle after any cycle in which at least one dec[i] was 1, else 0.
REQ-025 grant_idx SHALL be loaded with the lowest index i having dec[i] = 1 whenever grant_valid is being set; otherwise it holds its value.
REQ-026 Latency: push at edge N -> requests high after edge N; grant at edge M -> grant_valid/grant_idx valid after edge M.
REQ-027 clr = 1 clears overflow and grant_err; a new error event in the same cycle as clr has priority and leaves the flag set.
REQ-028 Counters SHALL never wrap in either direction.
REQ-029 busy = |requests.

Reset
REQ-030 With rst_n = 0 at a rising edge: all cnt = 0, requests = 0, overflow = 0, grant_err = 0, grant_valid = 0, grant_idx = 0, busy = 0.
REQ-031 Reset SHALL dominate push, grants and clr in the same cycle; reset mid-operation discards all pending counts.
REQ-032 Outputs SHALL be defined (no X) from the first edge with rst_n = 0.

Verification
REQ-033 Reset, then push[3] for 1 cycle -> requests = 0x0008 next cycle; grants = 0x0008 for 1 cycle -> requests = 0, grant_valid = 1, grant_idx = 3 next cycle.
REQ-034 push[0] for 9 consecutive cycles with no grants -> cnt[0] = 7, overflow[0] = 1 from the 8th push; then 7 grants[0] -> requests[0] drops after the 7th grant.
REQ-035 cnt[5] = 7 and push[5] = 1 with grants[5] = 1 in the same cycle -> cnt[5] stays 7, overflow[5] stays 0.
REQ-036 grants = 0x0100 while cnt[8] = 0 -> grant_err = 1, grant_valid = 0; then clr = 1 -> grant_err = 0.
REQ-037 push = 0xFFFF for 2 cycles, connected to round_robin -> each client granted exactly twice within 32 cycles; busy falls to 0 and grant_err stays 0.
REQ-038 rst_n driven low for 1 cycle with cnt[2] = 4 -> all outputs reset values next cycle; no grant_valid pulse.
